trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller.sv | 197 +++++++++++++++++++
 tb/tb_trap_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Trap/mret sequencer: turns a pipeline trap or mret request into a fixed series of CSR writes
// followed by a one-cycle PC redirect. Define TRAP_CTRL_MTVAL_EN to include the mtval write.
module trap_controller #(
  parameter int unsigned CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_valid,
  input  logic [3:0]            exc_src,
  input  logic [31:0]           exc_pc,
  input  logic [31:0]           exc_tval,
  output logic                  exc_ready,
  input  logic                  mret_valid,
  input  logic                  pl_csr_r_en,
  input  logic                  pl_csr_w_en,
  input  logic [2:0]            pl_csr_op,
  input  logic [CSR_ADDR_W-1:0] pl_csr_addr,
  input  logic [31:0]           pl_csr_wdata,
  output logic [31:0]           pl_csr_rdata,
  output logic                  csr_r_en,
  output logic                  csr_w_en,
  output logic [2:0]            csr_op,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [31:0]           csr_wdata,
  input  logic [31:0]           csr_rdata,
  output logic                  busy,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] W_MEPC       = 3'd1;
  localparam logic [2:0] W_MCAUSE     = 3'd2;
`ifdef TRAP_CTRL_MTVAL_EN
  localparam logic [2:0] W_MTVAL      = 3'd3;
`endif
  localparam logic [2:0] W_MSTATUS    = 3'd4;
  localparam logic [2:0] MRET_MSTATUS = 3'd5;
  localparam logic [2:0] REDIRECT     = 3'd6;

  localparam logic [CSR_ADDR_W-1:0] ADDR_MSTATUS = CSR_ADDR_W'(12'h300);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MTVEC   = CSR_ADDR_W'(12'h305);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MEPC    = CSR_ADDR_W'(12'h341);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MCAUSE  = CSR_ADDR_W'(12'h342);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MTVAL   = CSR_ADDR_W'(12'h343);

  logic [2:0]  state_q, state_d;
  logic        is_mret_q, is_mret_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
`ifdef TRAP_CTRL_MTVAL_EN
  logic [31:0] tval_q, tval_d;
`else
  logic        unused_tval;
  assign unused_tval = ^exc_tval;
`endif

  logic       trap_req;
  logic [3:0] cause_enc;

  assign trap_req = exc_valid && (exc_src != 4'b0000);

  always_comb begin
    if (exc_src[3])      cause_enc = 4'd3;
    else if (exc_src[2]) cause_enc = 4'd11;
    else if (exc_src[1]) cause_enc = 4'd6;
    else                 cause_enc = 4'd4;
  end

  always_comb begin
    state_d        = state_q;
    is_mret_d      = is_mret_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
`ifdef TRAP_CTRL_MTVAL_EN
    tval_d         = tval_q;
`endif
    exc_ready      = 1'b0;
    busy           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    pl_csr_rdata   = 32'h0;
    csr_r_en       = 1'b1;
    csr_w_en       = 1'b1;
    csr_op         = 3'b001;
    csr_addr       = '0;
    csr_wdata      = 32'h0;

    case (state_q)
      IDLE: begin
        busy         = 1'b0;
        exc_ready    = trap_req || mret_valid;
        csr_r_en     = pl_csr_r_en;
        csr_w_en     = pl_csr_w_en && !exc_ready;
        csr_op       = pl_csr_op;
        csr_addr     = pl_csr_addr;
        csr_wdata    = pl_csr_wdata;
        pl_csr_rdata = csr_rdata;
        if (trap_req) begin
          state_d   = W_MEPC;
          is_mret_d = 1'b0;
          cause_d   = cause_enc;
          pc_d      = exc_pc;
`ifdef TRAP_CTRL_MTVAL_EN
          tval_d    = exc_tval;
`endif
        end else if (mret_valid) begin
          state_d   = MRET_MSTATUS;
          is_mret_d = 1'b1;
        end
      end
      W_MEPC: begin
        csr_addr  = ADDR_MEPC;
        csr_wdata = pc_q;
        state_d   = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_addr  = ADDR_MCAUSE;
        csr_wdata = {28'h0, cause_q};
`ifdef TRAP_CTRL_MTVAL_EN
        state_d   = W_MTVAL;
`else
        state_d   = W_MSTATUS;
`endif
      end
`ifdef TRAP_CTRL_MTVAL_EN
      W_MTVAL: begin
        csr_addr  = ADDR_MTVAL;
        csr_wdata = tval_q;
        state_d   = W_MSTATUS;
      end
`endif
      // Same-cycle read-modify-write: MPIE <= MIE, MIE <= 0, MPP <= M.
      W_MSTATUS: begin
        csr_addr         = ADDR_MSTATUS;
        csr_wdata        = csr_rdata;
        csr_wdata[7]     = csr_rdata[3];
        csr_wdata[3]     = 1'b0;
        csr_wdata[12:11] = 2'b11;
        state_d          = REDIRECT;
      end
      MRET_MSTATUS: begin
        csr_addr         = ADDR_MSTATUS;
        csr_wdata        = csr_rdata;
        csr_wdata[3]     = csr_rdata[7];
        csr_wdata[7]     = 1'b1;
        csr_wdata[12:11] = 2'b00;
        state_d          = REDIRECT;
      end
      // Writes the read value back so the access stays a plain read in effect.
      REDIRECT: begin
        csr_addr       = is_mret_q ? ADDR_MEPC : ADDR_MTVEC;
        csr_wdata      = csr_rdata;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_d        = IDLE;
      end
      default: begin
        csr_r_en = 1'b0;
        csr_w_en = 1'b0;
        state_d  = IDLE;
      end
    endcase

    // Reset is synchronous, so outputs are quiesced combinationally during the reset cycle.
    if (rst) begin
      exc_ready      = 1'b0;
      busy           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      pl_csr_rdata   = 32'h0;
      csr_r_en       = 1'b0;
      csr_w_en       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_mret_q <= 1'b0;
      cause_q   <= 4'h0;
      pc_q      <= 32'h0;
`ifdef TRAP_CTRL_MTVAL_EN
      tval_q    <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      is_mret_q <= is_mret_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
`ifdef TRAP_CTRL_MTVAL_EN
      tval_q    <= tval_d;
`endif
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: a behavioural CSR file plus a per-cycle reference model of the
// trap/mret protocol, directed scenarios with literal expectations, then random traffic.
module tb_trap_controller;

`ifdef TRAP_CTRL_MTVAL_EN
  localparam int TLAT = 5;
`else
  localparam int TLAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0;
  logic [3:0]  exc_src = 4'h0;
  logic [31:0] exc_pc = 32'h0;
  logic [31:0] exc_tval = 32'h0;
  logic        exc_ready;
  logic        mret_valid = 1'b0;
  logic        pl_csr_r_en = 1'b0;
  logic        pl_csr_w_en = 1'b0;
  logic [2:0]  pl_csr_op = 3'b001;
  logic [11:0] pl_csr_addr = 12'h0;
  logic [31:0] pl_csr_wdata = 32'h0;
  logic [31:0] pl_csr_rdata;
  logic        csr_r_en, csr_w_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;
  bit done = 1'b0;
  bit mem_clr = 1'b1;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  trap_controller #(.CSR_ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_src(exc_src), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .exc_ready(exc_ready), .mret_valid(mret_valid),
    .pl_csr_r_en(pl_csr_r_en), .pl_csr_w_en(pl_csr_w_en), .pl_csr_op(pl_csr_op),
    .pl_csr_addr(pl_csr_addr), .pl_csr_wdata(pl_csr_wdata), .pl_csr_rdata(pl_csr_rdata),
    .csr_r_en(csr_r_en), .csr_w_en(csr_w_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // CSR unit: combinational read, write on op 001.
  assign csr_rdata = mem[csr_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else if (csr_w_en && csr_op == 3'b001) begin
      mem[csr_addr] <= csr_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Reference model: remembers what an accepted request must do and when the redirect is due.
  int          m_phase = 0;
  int          m_lat = 0;
  bit          m_is_mret = 1'b0;
  logic [31:0] m_target, m_mepc, m_cause, m_tval, m_old_tval, m_mstatus;

  function automatic logic [31:0] cause_of(input logic [3:0] src);
    if (src[3]) return 32'd3;
    if (src[2]) return 32'd11;
    if (src[1]) return 32'd6;
    return 32'd4;
  endfunction

  initial begin : compare
    logic        e_ready, e_busy, e_rv, e_wen;
    logic [31:0] e_rpc, e_rdata;
    while (!done) begin
      @(negedge clk);
      e_rdata = 32'h0;
      if (rst) begin
        e_ready = 0; e_busy = 0; e_rv = 0; e_rpc = 0; e_wen = 0;
        m_phase = 0;
      end else if (m_phase == 0) begin
        e_ready = (exc_valid && exc_src != 0) || mret_valid;
        e_busy  = 0; e_rv = 0; e_rpc = 0;
        e_wen   = pl_csr_w_en && !e_ready;
        e_rdata = mem[pl_csr_addr];
        check("pl_rdata", pl_csr_rdata, e_rdata);
        if (exc_valid && exc_src != 0) begin
          m_is_mret  = 0;
          m_lat      = TLAT;
          m_target   = mem[12'h305] & ~32'h3;
          m_mepc     = exc_pc;
          m_cause    = cause_of(exc_src);
          m_tval     = exc_tval;
          m_old_tval = mem[12'h343];
          m_mstatus  = (mem[12'h300] & ~32'h1888) | (32'(mem[12'h300][3]) << 7) | 32'h1800;
          m_phase    = 1;
        end else if (mret_valid) begin
          m_is_mret  = 1;
          m_lat      = 2;
          m_target   = mem[12'h341] & ~32'h3;
          m_mstatus  = (mem[12'h300] & ~32'h1888) | (32'(mem[12'h300][7]) << 3) | 32'h80;
          m_phase    = 1;
        end
      end else begin
        e_ready = 0; e_busy = 1; e_wen = 1;
        e_rv    = (m_phase == m_lat);
        e_rpc   = e_rv ? m_target : 32'h0;
        check("pl_rdata_busy", pl_csr_rdata, 32'h0);
        if (e_rv) begin
          check("mstatus", mem[12'h300], m_mstatus);
          if (!m_is_mret) begin
            check("mepc", mem[12'h341], m_mepc);
            check("mcause", mem[12'h342], m_cause);
`ifdef TRAP_CTRL_MTVAL_EN
            check("mtval", mem[12'h343], m_tval);
`else
            check("mtval_kept", mem[12'h343], m_old_tval);
`endif
          end
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      check("exc_ready", 32'(exc_ready), 32'(e_ready));
      check("busy", 32'(busy), 32'(e_busy));
      check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
      check("redirect_pc", redirect_pc, e_rpc);
      check("csr_w_en", 32'(csr_w_en), 32'(e_wen));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_valid = 0; exc_src = 0; exc_pc = 0; exc_tval = 0; mret_valid = 0;
    pl_csr_r_en = 0; pl_csr_w_en = 0; pl_csr_op = 3'b001; pl_csr_addr = 0; pl_csr_wdata = 0;
  endtask

  task automatic pl_write(input logic [11:0] addr, input logic [31:0] data);
    pl_csr_r_en = 1; pl_csr_w_en = 1; pl_csr_op = 3'b001;
    pl_csr_addr = addr; pl_csr_wdata = data;
    tick();
    clear_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [11:0] addr_set [6];

  initial begin : stim
    addr_set[0] = 12'h300; addr_set[1] = 12'h305; addr_set[2] = 12'h340;
    addr_set[3] = 12'h341; addr_set[4] = 12'h342; addr_set[5] = 12'h343;
    clear_inputs();
    rst = 1; mem_clr = 1;
    tick(); tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_redirect", 32'(redirect_valid), 32'h0);
    check("rst_wen", 32'(csr_w_en), 32'h0);
    tick();
    rst = 0; mem_clr = 0;
    tick();

    // ecall, MIE=1, mtvec=0x8001
    pl_write(12'h305, 32'h8001);
    pl_write(12'h300, 32'h8);
    exc_valid = 1; exc_src = 4'b0100; exc_pc = 32'h100;
    @(negedge clk);
    check("ecall_accept", 32'(exc_ready), 32'h1);
    tick(); clear_inputs();
    run(TLAT - 1);
    @(negedge clk);
    check("ecall_rv", 32'(redirect_valid), 32'h1);
    check("ecall_rpc", redirect_pc, 32'h8000);
    tick();
    check("ecall_mepc", mem[12'h341], 32'h100);
    check("ecall_mcause", mem[12'h342], 32'd11);
    check("ecall_mstatus", mem[12'h300], 32'h1880);

    // ebreak+ecall together
    exc_valid = 1; exc_src = 4'b1100; exc_pc = 32'h200;
    tick(); clear_inputs();
    run(TLAT);
    check("ebreak_mcause", mem[12'h342], 32'd3);

    // store misaligned with tval
    pl_write(12'h343, 32'hdead);
    exc_valid = 1; exc_src = 4'b0010; exc_pc = 32'h300; exc_tval = 32'h2002;
    tick(); clear_inputs();
    run(TLAT - 1);
    @(negedge clk);
    check("store_rv", 32'(redirect_valid), 32'h1);
    tick();
    check("store_mcause", mem[12'h342], 32'd6);
`ifdef TRAP_CTRL_MTVAL_EN
    check("store_mtval", mem[12'h343], 32'h2002);
`else
    check("store_mtval", mem[12'h343], 32'hdead);
`endif

    // mret, mepc=0x104, MPIE=1
    pl_write(12'h341, 32'h104);
    pl_write(12'h300, 32'h1880);
    mret_valid = 1;
    tick(); clear_inputs();
    tick();
    @(negedge clk);
    check("mret_rv", 32'(redirect_valid), 32'h1);
    check("mret_rpc", redirect_pc, 32'h104);
    tick();
    check("mret_mstatus", mem[12'h300], 32'h88);

    // trap + mret + pipeline write in one cycle
    pl_write(12'h340, 32'h55);
    exc_valid = 1; exc_src = 4'b0001; exc_pc = 32'h400; mret_valid = 1;
    pl_csr_w_en = 1; pl_csr_r_en = 1; pl_csr_addr = 12'h340; pl_csr_wdata = 32'haa;
    @(negedge clk);
    check("both_accept", 32'(exc_ready), 32'h1);
    check("both_no_plwrite", 32'(csr_w_en), 32'h0);
    tick();
    exc_valid = 0; exc_src = 0; pl_csr_w_en = 0; pl_csr_r_en = 0;
    run(TLAT);
    @(negedge clk);
    check("held_mret_accept", 32'(exc_ready), 32'h1);
    check("both_mscratch", mem[12'h340], 32'h55);
    check("both_mcause", mem[12'h342], 32'd4);
    tick(); mret_valid = 0;
    run(3);

    // reset in W_MCAUSE
    pl_write(12'h342, 32'h77);
    exc_valid = 1; exc_src = 4'b0001; exc_pc = 32'h500;
    tick(); clear_inputs();
    tick();
    rst = 1;
    @(negedge clk);
    check("rstmid_wen", 32'(csr_w_en), 32'h0);
    tick(); rst = 0;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'h0);
    run(TLAT + 2);
    check("rstmid_mcause", mem[12'h342], 32'h77);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      exc_valid    = ($urandom_range(0, 3) == 0);
      exc_src      = 4'($urandom);
      exc_pc       = $urandom;
      exc_tval     = $urandom;
      mret_valid   = ($urandom_range(0, 4) == 0);
      pl_csr_r_en  = 1'($urandom);
      pl_csr_w_en  = 1'($urandom);
      pl_csr_op    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001;
      pl_csr_addr  = addr_set[$urandom_range(0, 5)];
      pl_csr_wdata = $urandom;
      tick();
    end
    rst = 0;
    clear_inputs();
    run(8);

    done = 1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
